toggle_line_decoder: RTL
========================

Name: toggle_line_decoder

Overview:
- Receive-side counterpart of the team's toggle (T-flip-flop) line encoder. The line toggles for a 1 bit and holds for a 0 bit.
- Recovers the toggle bit stream, hunts for the 8'h7E flag, removes stuffed zeros and assembles LSB-first bytes.
- Reports frame boundaries, frame length and error/abort conditions to the packet layer above.

Parameters:
- MAX_LEN, 256, maximum data bytes per frame before overflow error.
- LEN_W, 9, width of frame_len; must hold MAX_LEN.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- bit_en  input  1  strobe; line_in is sampled only on cycles where bit_en=1.
- line_in  input  1  toggle-encoded serial line.
- data_out  output  8  assembled byte, LSB = first received data bit.
- data_valid  output  1  one-cycle pulse, data_out valid.
- frame_end  output  1  one-cycle pulse on a valid closing flag.
- frame_len  output  LEN_W  byte count of the closed frame; valid with frame_end.
- frame_err  output  1  one-cycle pulse: misaligned closing flag or length overflow.
- abort  output  1  one-cycle pulse: seven or more consecutive 1s inside a frame.
- in_frame  output  1  high while in RECV.

Behaviour:
- Reset (rst=0, asynchronous):
  - line_prev=0.
  - Shift history sr=0, bit_cnt=0, ones=0, byte_cnt=0, state=IDLE.
  - All outputs 0, including data_out and frame_len.
- Decode: on a bit_en cycle, d = line_in ^ line_prev, then line_prev <= line_in. With bit_en=0 nothing changes and all pulses are 0.
- Pulse outputs are registered, assert on the clock edge that samples the triggering bit, and are low on every other cycle.
- IDLE:
  - sr <= {d, sr[7:1]}.
  - When the new sr == 8'h7E: go to RECV with bit_cnt=0, ones=0, byte_cnt=0.
- RECV, per sampled d, in priority order:
  1. ones==5 and d==0: stuffed zero. Discard it; ones=0.
  2. ones==6 and d==0: flag detected.
     - bit_cnt==7 and byte_cnt>0: frame_end=1, frame_len=byte_cnt.
     - bit_cnt==7 and byte_cnt==0: idle fill; no pulse.
     - bit_cnt!=7: frame_err=1.
     - In all three cases: stay in RECV, bit_cnt=0, ones=0, byte_cnt=0. Shared and back-to-back flags are legal.
  3. ones==6 and d==1: abort=1, go to IDLE, sr=0.
  4. Otherwise, store d at position bit_cnt.
     - ones = d ? ones+1 : 0.
     - On the 8th bit: data_out=byte, data_valid=1, bit_cnt=0, byte_cnt+1.
     - If byte_cnt would exceed MAX_LEN: frame_err=1 instead of data_valid, go to IDLE.
- A misaligned flag can emit one spurious byte before frame_err. The packet layer drops any frame ending in frame_err.
- in_frame equals (state==RECV), registered.
- frame_err and frame_end are never high in the same cycle. data_valid and frame_end are never high in the same cycle.
- Reset mid-frame: everything returns to reset values immediately. A partial byte is discarded with no pulse.
- Line polarity: only toggles matter, so an inverted line decodes identically. The first bit after reset assumes line_prev=0.

Test Plan:
- Reset then hunt: rst low 2 cycles, release; drive toggle-encoded 7E, byte A5, 7E with bit_en every cycle -> data_valid once with data_out=8'hA5; frame_end once with frame_len=1; in_frame=1 after the first flag.
- Stuffing: payload byte 8'hFF (line carries 11111 0 111) -> data_out=8'hFF; stuffed zero removed; no frame_err.
- Abort: after opening flag, send seven consecutive 1s -> abort pulse on the 7th 1; in_frame falls; no frame_end; a later 7E re-enters RECV.
- Misaligned close: flag, 3 data bits, flag -> frame_err pulse, no frame_end; next aligned frame with 8'h3C -> data_out=8'h3C, frame_end with frame_len=1.
- Gapped strobe and back-to-back frames: bit_en high 1 cycle in 3; frames 7E,12,34,7E,56,7E -> bytes 12, 34 then frame_end with frame_len=2; byte 56 then frame_end with frame_len=1; no pulse on bit_en=0 cycles.
- Async reset mid-byte: rst low for half a cycle after 4 data bits -> all outputs 0 immediately, state IDLE; no data_valid until a new flag and 8 bits.

Source files
------------

// File: rtl/toggle_line_decoder.sv
// Receive side of the toggle line code: recovers bits from line transitions,
// hunts for the 7E flag, removes stuffed zeros and assembles LSB-first bytes.
module toggle_line_decoder #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             line_in,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             frame_end,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err,
  output logic             abort,
  output logic             in_frame
);

  typedef enum logic {IDLE, RECV} state_e;

  state_e           state_q, state_d;
  logic             line_prev_q, line_prev_d;
  logic [6:0]       sr_q, sr_d;        // last seven decoded bits while hunting
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       ones_q, ones_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_end_q, frame_end_d;
  logic             frame_err_q, frame_err_d;
  logic             abort_q, abort_d;
  logic             d;
  logic [7:0]       window;

  assign d      = line_in ^ line_prev_q;
  assign window = {d, sr_q};

  always_comb begin
    state_d      = state_q;
    line_prev_d  = line_prev_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    byte_cnt_d   = byte_cnt_q;
    byte_d       = byte_q;
    data_out_d   = data_out_q;
    frame_len_d  = frame_len_q;
    data_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    frame_err_d  = 1'b0;
    abort_d      = 1'b0;
    if (bit_en) begin
      line_prev_d = line_in;
      case (state_q)
        IDLE: begin
          sr_d = window[7:1];
          if (window == 8'h7E) begin
            state_d    = RECV;
            bit_cnt_d  = '0;
            ones_d     = '0;
            byte_cnt_d = '0;
          end
        end
        RECV: begin
          if (ones_q == 3'd5 && !d) begin
            ones_d = '0;
          end else if (ones_q == 3'd6 && !d) begin
            // Closing/opening flag; zero-length aligned frames are idle fill.
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q != '0) begin
                frame_end_d = 1'b1;
                frame_len_d = byte_cnt_q;
              end
            end else begin
              frame_err_d = 1'b1;
            end
            bit_cnt_d  = '0;
            ones_d     = '0;
            byte_cnt_d = '0;
          end else if (ones_q == 3'd6) begin
            abort_d = 1'b1;
            state_d = IDLE;
            sr_d    = '0;
          end else begin
            byte_d[bit_cnt_q] = d;
            ones_d    = d ? ones_q + 3'd1 : 3'd0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q >= LEN_W'(MAX_LEN)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
                sr_d        = '0;
              end else begin
                data_out_d   = byte_d;
                data_valid_d = 1'b1;
                byte_cnt_d   = byte_cnt_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      line_prev_q  <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      byte_cnt_q   <= '0;
      byte_q       <= '0;
      data_out_q   <= '0;
      frame_len_q  <= '0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_prev_q  <= line_prev_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_q       <= byte_d;
      data_out_q   <= data_out_d;
      frame_len_q  <= frame_len_d;
      data_valid_q <= data_valid_d;
      frame_end_q  <= frame_end_d;
      frame_err_q  <= frame_err_d;
      abort_q      <= abort_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_end  = frame_end_q;
  assign frame_len  = frame_len_q;
  assign frame_err  = frame_err_q;
  assign abort      = abort_q;
  assign in_frame   = (state_q == RECV);

endmodule
